// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op encodings,
// controller state type and the iteration count.
package mips_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam int MDU_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FIXUP = 2'b10
  } mdu_state_t;

endpackage

// File: rtl/mips_mdu_step.sv
// One iteration of the MDU datapath, purely combinational.
// Multiply: acc += b when the current multiplier bit is set, then b<<1, m>>1.
// Divide: acc = {remainder, dividend/quotient}; restoring trial subtract of
// the divisor (b low half), shifting one quotient bit in at the LSB.
module mips_mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0]   m_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [2*WIDTH-1:0] b_o,
  output logic [WIDTH-1:0]   m_o
);

  logic [WIDTH:0] trial_s;

  // Single shift-add or trial-subtract step selected by operation class.
  always_comb begin
    acc_o   = acc_i;
    b_o     = b_i;
    m_o     = m_i;
    trial_s = {(WIDTH+1){1'b0}};
    if (is_div_i) begin
      // Partial remainder with the next dividend bit shifted in, minus divisor.
      trial_s = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]} - {1'b0, b_i[WIDTH-1:0]};
      if (!trial_s[WIDTH]) begin
        acc_o = {trial_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      if (m_i[0]) begin
        acc_o = acc_i + b_i;
      end else begin
        acc_o = acc_i;
      end
      b_o = {b_i[2*WIDTH-2:0], 1'b0};
      m_o = {1'b0, m_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_mdu.sv
// Iterative multiply/divide unit owning HI/LO for the multi-cycle MIPS core.
// Signed ops run on magnitudes; the sign is restored in FIXUP.
// Optional build macro: MDU_EARLY_TERM_EN - multiplies leave RUN as soon as
// the remaining multiplier bits are all zero (divide latency unchanged).
module mips_mdu
  import mips_pkg::*;
#(
  parameter int WIDTH = MDU_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hiwe,
  input  logic             lowe,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  mdu_state_t         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] b_q;
  logic [WIDTH-1:0]   m_q;
  logic               is_div_q;
  logic               sign_q_q;   // quotient / product sign
  logic               sign_r_q;   // remainder sign
  logic               div0_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               is_signed_d;
  logic [WIDTH-1:0]   a_mag_d;
  logic [WIDTH-1:0]   b_mag_d;
  logic [2*WIDTH-1:0] step_acc_d;
  logic [2*WIDTH-1:0] step_b_d;
  logic [WIDTH-1:0]   step_m_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;

  mips_mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .b_i      (b_q),
    .m_i      (m_q),
    .acc_o    (step_acc_d),
    .b_o      (step_b_d),
    .m_o      (step_m_d)
  );

  // Operand magnitudes for signed ops, raw operands for unsigned ops.
  always_comb begin
    is_signed_d = ~op[0];
    if (is_signed_d && srca[WIDTH-1]) begin
      a_mag_d = ~srca + ONE_W;
    end else begin
      a_mag_d = srca;
    end
    if (is_signed_d && srcb[WIDTH-1]) begin
      b_mag_d = ~srcb + ONE_W;
    end else begin
      b_mag_d = srcb;
    end
  end

  // Sign correction of the magnitude result into HI/LO values.
  always_comb begin
    prod_d = acc_q;
    hi_d   = acc_q[2*WIDTH-1:WIDTH];
    lo_d   = acc_q[WIDTH-1:0];
    if (is_div_q) begin
      if (sign_r_q) begin
        hi_d = ~acc_q[2*WIDTH-1:WIDTH] + ONE_W;
      end else begin
        hi_d = acc_q[2*WIDTH-1:WIDTH];
      end
      // Divide by zero leaves all ones; the remainder path already holds srca.
      if (div0_q) begin
        lo_d = {WIDTH{1'b1}};
      end else if (sign_q_q) begin
        lo_d = ~acc_q[WIDTH-1:0] + ONE_W;
      end else begin
        lo_d = acc_q[WIDTH-1:0];
      end
    end else begin
      if (sign_q_q) begin
        prod_d = ~acc_q + ONE_2W;
      end else begin
        prod_d = acc_q;
      end
      hi_d = prod_d[2*WIDTH-1:WIDTH];
      lo_d = prod_d[WIDTH-1:0];
    end
  end

  // Controller FSM with iteration state, HI/LO and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      b_q      <= {(2*WIDTH){1'b0}};
      m_q      <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hiwe) hi_q <= wd;
          if (lowe) lo_q <= wd;
          if (start) begin
            is_div_q <= op[1];
            sign_q_q <= is_signed_d & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            sign_r_q <= is_signed_d & op[1] & srca[WIDTH-1];
            div0_q   <= op[1] & (srcb == {WIDTH{1'b0}});
            cnt_q    <= {CNT_W{1'b0}};
            b_q      <= {{WIDTH{1'b0}}, b_mag_d};
            if (op[1]) begin
              acc_q <= {{WIDTH{1'b0}}, a_mag_d};
              b_q   <= {{WIDTH{1'b0}}, b_mag_d};
              m_q   <= {WIDTH{1'b0}};
            end else begin
              acc_q <= {(2*WIDTH){1'b0}};
              b_q   <= {{WIDTH{1'b0}}, a_mag_d};
              m_q   <= b_mag_d;
            end
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= step_acc_d;
          b_q   <= step_b_d;
          m_q   <= step_m_d;
          cnt_q <= cnt_q + CNT_W'(1);
`ifdef MDU_EARLY_TERM_EN
          if ((cnt_q == CNT_LAST) || (!is_div_q && (step_m_d == {WIDTH{1'b0}}))) begin
            state_q <= FIXUP;
          end
`else
          if (cnt_q == CNT_LAST) begin
            state_q <= FIXUP;
          end
`endif
        end
        FIXUP: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
